// File: rtl/delta_spike_decoder.sv
// Delta-modulation spike decoder: saturating sample reconstruction plus run-length event FIFO.
// Optional per-direction spike counters (up_cnt/down_cnt) are enabled by defining DELTA_DEC_STATS_EN.
module delta_spike_decoder #(
  parameter int DW    = 4,
  parameter int RW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    spike_in,
  input  logic [DW-1:0] threshold,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          flush,
  output logic [DW-1:0] recon,
  output logic          recon_sat,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [RW+1:0] ev_data,
  output logic          ovf,
  output logic          err
`ifdef DELTA_DEC_STATS_EN
  ,
  output logic [15:0]   up_cnt,
  output logic [15:0]   down_cnt
`endif
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [RW-1:0] RUN_MAX  = '1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]    SYM_UP   = 2'b01;
  localparam logic [1:0]    SYM_DN   = 2'b10;

  logic [DW-1:0] recon_q, recon_d;
  logic          sat_q, sat_d;
  logic [1:0]    dir_q, dir_d;
  logic [RW-1:0] run_q, run_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic [RW+1:0] mem_q [DEPTH];
  logic          ovf_q, err_q;
  logic          illegal, push, pop, full, push_ok, drop;
  logic [1:0]    sym;

  // Return value is {clamped, result}.
  function automatic logic [DW:0] sat_up(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DW]) return {1'b1, {DW{1'b1}}};
    return {1'b0, s[DW-1:0]};
  endfunction

  function automatic logic [DW:0] sat_dn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) return {1'b1, {DW{1'b0}}};
    return {1'b0, d[DW-1:0]};
  endfunction

  assign illegal = en && (spike_in == 2'b11);
  assign sym     = (en && !illegal) ? spike_in : 2'b00;

  always_comb begin
    recon_d = recon_q;
    sat_d   = sat_q;
    if (load) begin
      recon_d = load_val;
      sat_d   = 1'b0;
    end else if (en) begin
      unique case (sym)
        SYM_UP:  {sat_d, recon_d} = sat_up(recon_q, threshold);
        SYM_DN:  {sat_d, recon_d} = sat_dn(recon_q, threshold);
        default: sat_d = 1'b0;
      endcase
    end
  end

  // Run encoder: every push carries the run being closed, never the incoming symbol.
  always_comb begin
    dir_d = dir_q;
    run_d = run_q;
    push  = 1'b0;
    if (flush && run_q != '0) begin
      push  = 1'b1;
      dir_d = en ? sym : 2'b00;
      run_d = en ? RW'(1) : '0;
    end else if (en && sym == dir_q && run_q != RUN_MAX) begin
      run_d = run_q + 1'b1;
    end else if (en) begin
      push  = (run_q != '0);
      dir_d = sym;
      run_d = RW'(1);
    end
  end

  assign full    = (cnt_q == FULL_CNT);
  assign pop     = (cnt_q != '0) && ev_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      recon_q <= '0;
      sat_q   <= 1'b0;
      dir_q   <= 2'b00;
      run_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      recon_q <= recon_d;
      sat_q   <= sat_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_ok) wr_q <= wr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop)    ovf_q <= 1'b1;
      if (illegal) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {dir_q, run_q};
  end

`ifdef DELTA_DEC_STATS_EN
  logic [15:0] up_q, dn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q <= '0;
      dn_q <= '0;
    end else begin
      if (sym == SYM_UP && up_q != 16'hFFFF) up_q <= up_q + 1'b1;
      if (sym == SYM_DN && dn_q != 16'hFFFF) dn_q <= dn_q + 1'b1;
    end
  end

  assign up_cnt   = up_q;
  assign down_cnt = dn_q;
`endif

  assign recon     = recon_q;
  assign recon_sat = sat_q;
  assign ev_valid  = (cnt_q != '0);
  assign ev_data   = ev_valid ? mem_q[rd_q] : '0;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_delta_spike_decoder.sv
// Bench for delta_spike_decoder: hand-written vector table, a 64-spike run-limit sequence,
// and randomized traffic checked against a queue-based behavioural model.
module tb_delta_spike_decoder;
  localparam int DW = 4, RW = 6, DEPTH = 4;
  localparam int MAXV = (1 << DW) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, en = 1'b0, load = 1'b0, flush = 1'b0, ev_ready = 1'b0;
  logic [1:0]    spike_in = 2'b00;
  logic [DW-1:0] threshold = '0, load_val = '0;
  logic [DW-1:0] recon;
  logic          recon_sat, ev_valid, ovf, err;
  logic [RW+1:0] ev_data;
`ifdef DELTA_DEC_STATS_EN
  logic [15:0]   up_cnt, down_cnt;
`endif

  delta_spike_decoder #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .threshold(threshold),
    .load(load), .load_val(load_val), .flush(flush), .recon(recon), .recon_sat(recon_sat),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ovf(ovf), .err(err)
`ifdef DELTA_DEC_STATS_EN
    , .up_cnt(up_cnt), .down_cnt(down_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural reference: plain integers and a queue of events.
  int m_recon, m_sat, m_dir, m_cnt, m_ovf, m_err, m_up, m_dn;
  int m_q[$];

  task automatic model(input int r, input int e, input int sp, input int th, input int ld,
                       input int lv, input int fl, input int rdy);
    int s, t, ev, have;
    if (r != 0) begin
      m_recon = 0; m_sat = 0; m_dir = 0; m_cnt = 0; m_ovf = 0; m_err = 0; m_up = 0; m_dn = 0;
      m_q.delete();
      return;
    end
    s = (e != 0 && sp != 3) ? sp : 0;
    if (e != 0 && sp == 3) m_err = 1;
    if (ld != 0) begin
      m_recon = lv; m_sat = 0;
    end else if (e != 0) begin
      if (s == 1) begin
        t = m_recon + th; m_sat = (t > MAXV); m_recon = (t > MAXV) ? MAXV : t;
      end else if (s == 2) begin
        t = m_recon - th; m_sat = (t < 0); m_recon = (t < 0) ? 0 : t;
      end else m_sat = 0;
    end
    if (s == 1 && m_up < 65535) m_up++;
    if (s == 2 && m_dn < 65535) m_dn++;
    have = 0;
    ev = m_dir * (RMAX + 1) + m_cnt;
    if (fl != 0 && m_cnt != 0) begin
      have = 1;
      m_dir = (e != 0) ? s : 0; m_cnt = (e != 0) ? 1 : 0;
    end else if (e != 0) begin
      if (s == m_dir && m_cnt < RMAX) m_cnt++;
      else begin
        have = (m_cnt != 0); m_dir = s; m_cnt = 1;
      end
    end
    if (m_q.size() > 0 && rdy != 0) void'(m_q.pop_front());
    if (have != 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] sp, input logic [3:0] th,
                      input logic ld, input logic [3:0] lv, input logic fl, input logic rdy);
    rst = r; en = e; spike_in = sp; threshold = th; load = ld; load_val = lv;
    flush = fl; ev_ready = rdy;
    model(int'(r), int'(e), int'(sp), int'(th), int'(ld), int'(lv), int'(fl), int'(rdy));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, e; logic [1:0] sp; logic [3:0] th; logic ld; logic [3:0] lv; logic fl, rdy;
    logic [3:0] x_recon; logic x_sat, x_vld; logic [7:0] x_data; logic x_ovf, x_err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, e, input logic [1:0] sp, input logic [3:0] th, input logic ld,
                     input logic [3:0] lv, input logic fl, rdy, input logic [3:0] xr,
                     input logic xs, xv, input logic [7:0] xd, input logic xo, xe);
    vec_t v;
    v.r = r; v.e = e; v.sp = sp; v.th = th; v.ld = ld; v.lv = lv; v.fl = fl; v.rdy = rdy;
    v.x_recon = xr; v.x_sat = xs; v.x_vld = xv; v.x_data = xd; v.x_ovf = xo; v.x_err = xe;
    tbl.push_back(v);
  endtask

  logic [1:0] rsp;
  logic       rr, re, rl, rf, rrdy;

  initial begin
    // r e sp th ld lv fl rdy | recon sat vld data ovf err
    add(1,0,0,0, 0,0, 0,1,  0,0,0,8'h00,0,0);  // reset
    add(0,1,1,3, 0,0, 0,1,  3,0,0,8'h00,0,0);  // up x3 then down
    add(0,1,1,3, 0,0, 0,1,  6,0,0,8'h00,0,0);
    add(0,1,1,3, 0,0, 0,1,  9,0,0,8'h00,0,0);
    add(0,1,2,3, 0,0, 0,1,  6,0,1,8'h43,0,0);
    add(0,0,0,3, 0,0, 0,1,  6,0,0,8'h00,0,0);
    add(0,0,0,3, 1,12,0,1, 12,0,0,8'h00,0,0);  // load then clamp high
    add(0,1,1,5, 0,0, 0,1, 15,1,1,8'h81,0,0);
    add(0,0,0,5, 1,2, 0,1,  2,0,0,8'h00,0,0);
    add(0,1,2,5, 0,0, 0,1,  0,1,1,8'h41,0,0);  // clamp low
    add(0,1,0,5, 0,0, 0,1,  0,0,1,8'h81,0,0);  // idle clears sat
    add(0,0,0,5, 0,0, 0,1,  0,0,0,8'h00,0,0);
    add(1,0,0,1, 0,0, 0,0,  0,0,0,8'h00,0,0);  // fill FIFO with ready low
    add(0,1,1,1, 0,0, 0,0,  1,0,0,8'h00,0,0);
    add(0,1,2,1, 0,0, 0,0,  0,0,1,8'h41,0,0);
    add(0,1,1,1, 0,0, 0,0,  1,0,1,8'h41,0,0);
    add(0,1,2,1, 0,0, 0,0,  0,0,1,8'h41,0,0);
    add(0,1,1,1, 0,0, 0,0,  1,0,1,8'h41,0,0);
    add(0,1,2,1, 0,0, 0,0,  0,0,1,8'h41,1,0);
    add(0,0,0,1, 0,0, 0,1,  0,0,1,8'h81,1,0);  // drain
    add(0,0,0,1, 0,0, 0,1,  0,0,1,8'h41,1,0);
    add(0,0,0,1, 0,0, 0,1,  0,0,1,8'h81,1,0);
    add(0,0,0,1, 0,0, 0,1,  0,0,0,8'h00,1,0);
    add(1,0,0,1, 0,0, 0,1,  0,0,0,8'h00,0,0);  // illegal symbol, down x2, flush
    add(0,1,3,1, 0,0, 0,1,  0,0,0,8'h00,0,1);
    add(0,1,2,1, 0,0, 0,1,  0,1,1,8'h01,0,1);
    add(0,1,2,1, 0,0, 0,1,  0,1,0,8'h00,0,1);
    add(0,0,0,1, 0,0, 1,1,  0,1,1,8'h82,0,1);
    add(0,0,0,1, 0,0, 1,1,  0,1,0,8'h00,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].sp, tbl[i].th, tbl[i].ld, tbl[i].lv, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("recon[%0d]", i), 16'(recon), 16'(tbl[i].x_recon));
      chk($sformatf("recon_sat[%0d]", i), 16'(recon_sat), 16'(tbl[i].x_sat));
      chk($sformatf("ev_valid[%0d]", i), 16'(ev_valid), 16'(tbl[i].x_vld));
      chk($sformatf("ev_data[%0d]", i), 16'(ev_data), 16'(tbl[i].x_data));
      chk($sformatf("ovf[%0d]", i), 16'(ovf), 16'(tbl[i].x_ovf));
      chk($sformatf("err[%0d]", i), 16'(err), 16'(tbl[i].x_err));
    end
`ifdef DELTA_DEC_STATS_EN
    chk("down_cnt_t6", down_cnt, 16'd2);
    chk("up_cnt_t6", up_cnt, 16'd0);
`endif

    // Run-length limit: 64 ups close a {01,63} event and restart at count 1.
    step(1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 64; i++) begin
      step(0, 1, 2'b01, 1, 0, 0, 0, 1);
      if (i == 63) chk("runmax_no_early_event", 16'(ev_valid), 16'd0);
    end
    chk("runmax_valid", 16'(ev_valid), 16'd1);
    chk("runmax_data", 16'(ev_data), 16'h7F);
    chk("runmax_recon", 16'(recon), 16'(MAXV));
    step(0, 0, 0, 1, 0, 0, 1, 1);
    chk("runmax_restart_data", 16'(ev_data), 16'h41);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    rsp = 2'b01;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        int k = $urandom_range(0, 19);
        rsp = (k < 9) ? 2'b01 : (k < 18) ? 2'b10 : (k == 18) ? 2'b00 : 2'b11;
      end
      rr   = ($urandom_range(0, 599) == 0);
      re   = ($urandom_range(0, 99) < 85);
      rl   = ($urandom_range(0, 99) < 5);
      rf   = ($urandom_range(0, 99) < 6);
      rrdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 15);
      step(rr, re, rsp, 4'($urandom_range(0, 15)), rl, 4'($urandom_range(0, 15)), rf, rrdy);
      chk("rnd_recon", 16'(recon), 16'(m_recon));
      chk("rnd_sat", 16'(recon_sat), 16'(m_sat));
      chk("rnd_valid", 16'(ev_valid), 16'(m_q.size() > 0));
      chk("rnd_data", 16'(ev_data), (m_q.size() > 0) ? 16'(m_q[0]) : 16'd0);
      chk("rnd_ovf", 16'(ovf), 16'(m_ovf));
      chk("rnd_err", 16'(err), 16'(m_err));
`ifdef DELTA_DEC_STATS_EN
      chk("rnd_up_cnt", up_cnt, 16'(m_up));
      chk("rnd_down_cnt", down_cnt, 16'(m_dn));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
